// File: rtl/shift_seq.sv
// Command sequencer for an 8-bit universal shift register: turns load/shift/rotate
// commands into per-cycle mode pins, counts shift cycles and pulses done on completion.
module shift_seq #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          c,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          cmd_rot,
    input  logic          cmd_fill,
    input  logic [CW-1:0] cmd_cnt,
    input  logic [W-1:0]  cmd_data,
    input  logic [W-1:0]  q,
    output logic          l,
    output logic          r,
    output logic          i,
    output logic [W-1:0]  d,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_UP   = 2'b11;

    logic [1:0]    state_r, state_s;
    logic [1:0]    op_r, op_s;
    logic          rot_r, rot_s;
    logic          fill_r, fill_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [W-1:0]  d_r, d_s;
    logic          l_r, l_s;
    logic          r_r, r_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          ready_r, ready_s;

    // Next-state and next-output decode; outputs are registered so they line up with state_r.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        rot_s   = rot_r;
        fill_s  = fill_r;
        cnt_s   = cnt_r;
        d_s     = d_r;
        l_s     = 1'b0;
        r_s     = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b0;
        ready_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_s   = cmd_op;
                    rot_s  = cmd_rot;
                    fill_s = cmd_fill;
                    cnt_s  = cmd_cnt;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_s = S_LOAD;
                            l_s     = 1'b1;
                            r_s     = 1'b1;
                            d_s     = cmd_data;
                        end
                        OP_DOWN, OP_UP: begin
                            if (cmd_cnt != '0) begin
                                state_s = S_SHIFT;
                                l_s     = ~cmd_op[0];
                                r_s     = cmd_op[0];
                            end else begin
                                state_s = S_DONE;
                                done_s  = 1'b1;
                            end
                        end
                        default: begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                        end
                    endcase
                end else begin
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end
            S_LOAD: begin
                state_s = S_DONE;
                done_s  = 1'b1;
            end
            S_SHIFT: begin
                // The counter still holding 1 means this edge performs the final shift.
                if (cnt_r == CW'(1)) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                    l_s   = ~op_r[0];
                    r_s   = op_r[0];
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, latched command fields and registered outputs.
    always_ff @(posedge c) begin
        if (rst) begin
            state_r <= S_IDLE;
            op_r    <= 2'b00;
            rot_r   <= 1'b0;
            fill_r  <= 1'b0;
            cnt_r   <= '0;
            d_r     <= '0;
            l_r     <= 1'b0;
            r_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            rot_r   <= rot_s;
            fill_r  <= fill_s;
            cnt_r   <= cnt_s;
            d_r     <= d_s;
            l_r     <= l_s;
            r_r     <= r_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    // Serial input follows q live so every shift cycle rotates the current register value.
    assign i = rot_r ? (op_r[0] ? q[W-1] : q[0]) : fill_r;

    assign l         = l_r;
    assign r         = r_r;
    assign d         = d_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_ready = ready_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq driving a behavioural universal shift register
// whose output is fed back as q.
module tb_shift_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          c = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_rot;
    logic          cmd_fill;
    logic [CW-1:0] cmd_cnt;
    logic [W-1:0]  cmd_data;
    logic [W-1:0]  q;
    logic          l, r, i;
    logic [W-1:0]  d;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic          rot;
        logic          fill;
        logic [CW-1:0] cnt;
        logic [W-1:0]  data;
        logic [W-1:0]  exp_q;
        int            exp_lat;
        int            exp_shifts;
        int            exp_loads;
    } vec_t;

    vec_t vecs[10];

    shift_seq #(.W(W), .CW(CW)) dut (
        .c(c), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rot(cmd_rot), .cmd_fill(cmd_fill), .cmd_cnt(cmd_cnt),
        .cmd_data(cmd_data), .q(q), .l(l), .r(r), .i(i), .d(d), .busy(busy), .done(done)
    );

    always #5 c = ~c;

    // Downstream universal shift register model (no reset).
    always @(posedge c) begin
        case ({l, r})
            2'b10:   q <= {i, q[W-1:1]};
            2'b01:   q <= {q[W-2:0], i};
            2'b11:   q <= d;
            default: q <= q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #2;
    endtask

    // Issue one command and follow it to its done pulse.
    task automatic run_cmd(input vec_t v);
        int lat, shifts, loads;
        logic bad_ready, bad_dir, bad_d;
        chk({v.name, " ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_rot   = v.rot;
        cmd_fill  = v.fill;
        cmd_cnt   = v.cnt;
        cmd_data  = v.data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_rot   = ~v.rot;
        cmd_fill  = ~v.fill;
        cmd_cnt   = ~v.cnt;
        cmd_data  = ~v.data;
        lat = 1; shifts = 0; loads = 0;
        bad_ready = 1'b0; bad_dir = 1'b0; bad_d = 1'b0;
        while (!done && lat < 40) begin
            if (cmd_ready || !busy) bad_ready = 1'b1;
            if (l && r) begin
                loads++;
                if (d !== v.data) bad_d = 1'b1;
            end else if (l || r) begin
                shifts++;
                if (l !== ~v.op[0]) bad_dir = 1'b1;
            end
            tick();
            lat++;
        end
        chk({v.name, " done_seen"}, 32'(done), 32'd1);
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " shift_cycles"}, 32'(shifts), 32'(v.exp_shifts));
        chk({v.name, " load_cycles"}, 32'(loads), 32'(v.exp_loads));
        chk({v.name, " flags_busy"}, {29'd0, bad_ready, bad_dir, bad_d}, 32'd0);
        chk({v.name, " q_at_done"}, 32'(q), 32'(v.exp_q));
        chk({v.name, " lr_at_done"}, {30'd0, l, r}, 32'd0);
        tick();
        chk({v.name, " done_one_cycle"}, {30'd0, done, cmd_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"load_a5",     2'b01, 1'b0, 1'b0, 4'd0,  8'hA5, 8'hA5, 2,  0, 1};
        vecs[1] = '{"down_fill3",  2'b10, 1'b0, 1'b0, 4'd3,  8'h00, 8'h14, 4,  3, 0};
        vecs[2] = '{"load_81",     2'b01, 1'b0, 1'b0, 4'd0,  8'h81, 8'h81, 2,  0, 1};
        vecs[3] = '{"rot_up1",     2'b11, 1'b1, 1'b0, 4'd1,  8'h00, 8'h03, 2,  1, 0};
        vecs[4] = '{"rot_down9",   2'b10, 1'b1, 1'b0, 4'd9,  8'h00, 8'h81, 10, 9, 0};
        vecs[5] = '{"up_cnt0",     2'b11, 1'b0, 1'b1, 4'd0,  8'h55, 8'h81, 1,  0, 0};
        vecs[6] = '{"nop",         2'b00, 1'b0, 1'b1, 4'd7,  8'h55, 8'h81, 1,  0, 0};
        vecs[7] = '{"up_fill1x4",  2'b11, 1'b0, 1'b1, 4'd4,  8'h00, 8'h1F, 5,  4, 0};
        vecs[8] = '{"down_fill12", 2'b10, 1'b0, 1'b1, 4'd12, 8'h00, 8'hFF, 13, 12, 0};
        vecs[9] = '{"load_3c",     2'b01, 1'b0, 1'b0, 4'd0,  8'h3C, 8'h3C, 2,  0, 1};

        q = 8'h5A;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rot = 1'b0;
        cmd_fill = 1'b0; cmd_cnt = 4'd0; cmd_data = 8'h00;
        repeat (3) tick();
        chk("reset_outputs", {25'd0, l, r, busy, done, cmd_ready, i, 1'b0}, {25'd0, 7'b0000100});
        chk("reset_d", 32'(d), 32'd0);
        chk("reset_q_untouched", 32'(q), 32'h5A);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) run_cmd(vecs[k]);

        // Rotate up by 15 on 0x3C is a net rotate down by one.
        run_cmd('{"rot_up15", 2'b11, 1'b1, 1'b0, 4'd15, 8'h00, 8'h1E, 16, 15, 0});

        // Back-to-back: second command held during the first is taken only after done.
        run_cmd('{"load_0f", 2'b01, 1'b0, 1'b0, 4'd0, 8'h0F, 8'h0F, 2, 0, 1});
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rot = 1'b0; cmd_fill = 1'b0;
        cmd_cnt = 4'd2; cmd_data = 8'h00;
        tick();
        cmd_op = 2'b01; cmd_data = 8'hAA; cmd_cnt = 4'd9; cmd_fill = 1'b1;
        chk("b2b_c1", {28'd0, l, r, cmd_ready, busy}, {28'd0, 4'b0101});
        tick();
        chk("b2b_c2", {28'd0, l, r, cmd_ready, busy}, {28'd0, 4'b0101});
        tick();
        chk("b2b_done", {28'd0, done, cmd_ready, l, r}, {28'd0, 4'b1000});
        chk("b2b_q_first", 32'(q), 32'h3C);
        tick();
        chk("b2b_idle_ready", {30'd0, cmd_ready, busy}, 32'd2);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_load_pins", {30'd0, l, r}, 32'd3);
        chk("b2b_load_d", 32'(d), 32'hAA);
        tick();
        chk("b2b_q_second", {23'd0, done, q}, {23'd1, 8'hAA});
        tick();

        // Reset during the second cycle of a five-step shift of 0xFF.
        run_cmd('{"load_ff", 2'b01, 1'b0, 1'b0, 4'd0, 8'hFF, 8'hFF, 2, 0, 1});
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rot = 1'b0; cmd_fill = 1'b0;
        cmd_cnt = 4'd5; cmd_data = 8'h00;
        tick();
        cmd_valid = 1'b0;
        chk("rst_shift_c1", {30'd0, l, r}, 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pins", {27'd0, l, r, done, busy, cmd_ready}, 32'd1);
        chk("rst_q_partial", 32'(q), 32'h3F);
        tick();
        chk("rst_no_done", {29'd0, done, cmd_ready, busy}, 32'd2);
        chk("rst_q_stable", 32'(q), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Command sequencer sitting directly upstream of the 8-bit universal shift register (per-bit clocked mux stage).
- Accepts load/shift/rotate commands over a valid/ready handshake and drives the register's mode pins (l, r), serial input (i) and parallel data (d).
- Counts shift cycles and reports completion with a one-cycle pulse.
- Observes the register output q to implement rotation.

Parameters:
- W, 8, register width; must match the downstream shift register.
- CW, 4, command shift-count width; max count 2^CW-1.

Ports:
- c  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 nop, 01 load, 10 shift-down (toward bit 0), 11 shift-up (toward bit W-1).
- cmd_rot  input  1  1 = rotate; 0 = fill with cmd_fill.
- cmd_fill  input  1  serial fill bit for non-rotate shifts.
- cmd_cnt  input  CW  number of shift cycles.
- cmd_data  input  W  parallel load value.
- q  input  W  current shift-register contents, fed back.
- l  output  1  shift-register mode pin l.
- r  output  1  shift-register mode pin r.
- i  output  1  shift-register serial input.
- d  output  W  shift-register parallel data.
- busy  output  1  a command is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Downstream mode encoding:
  - l=0 r=0: hold.
  - l=1 r=0: q[k] <= q[k+1], i enters bit W-1 (shift-down).
  - l=0 r=1: q[k] <= q[k-1], i enters bit 0 (shift-up).
  - l=1 r=1: q <= d (load).
- Reset: state IDLE; l=0, r=0, d=0, busy=0, done=0; cmd_ready=1 after reset. Shift-register contents are not touched (it has no reset).
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, busy=0, l=r=0.
  - Accept on the edge where cmd_valid && cmd_ready. Latch op, rot, fill, cnt, data.
  - op 01 -> LOAD.
  - op 10/11 with cnt>0 -> SHIFT.
  - op 10/11 with cnt=0 -> DONE.
  - op 00 -> DONE.
- LOAD: l=r=1, d=latched data, for exactly one cycle -> DONE. The register holds data after that edge.
- SHIFT:
  - Drive l/r per direction for exactly cnt consecutive cycles. Internal counter loads cnt and decrements each edge.
  - Leave to DONE on the edge where the counter equals 1.
  - i = rot ? (down ? q[0] : q[W-1]) : fill. This is combinational from q and latched fields, so each cycle sees the current register value.
- DONE: l=r=0, done=1 for one cycle -> IDLE.
- busy=1 in LOAD, SHIFT and DONE. cmd_ready=0 outside IDLE.
- Commands presented while busy are not accepted. The upstream source must hold cmd_valid; no queuing.
- Latency, accept edge to done: load = 2 cycles; shift = cnt+1 cycles; nop or cnt=0 = 1 cycle.
- At the done cycle, q reflects the final result.
- d holds the last loaded value outside LOAD. i is don't-care when l=r=0 but must not be X.
- cnt > W is executed literally:
  - rotate: net rotation cnt mod W;
  - fill: register fully filled after W cycles.
- rst asserted mid-command:
  - next edge returns to IDLE with l=r=0;
  - no done pulse;
  - partial shifts already applied remain in the register.
- Latched command fields are unaffected by changes on the cmd_* inputs while busy.

Test Plan:
- Reset, then load 0xA5 -> cmd_ready=0 for 2 cycles; one cycle of l=r=1, d=0xA5; done pulses; q=0xA5.
- After load 0xA5, shift-down, fill=0, cnt=3 -> exactly 3 cycles of l=1 r=0; q=0x14; done at 4th cycle after accept.
- After load 0x81, shift-up, rot=1, cnt=1 -> q=0x03. Then rotate-down, cnt=9 -> q=0x81 (9 mod 8 = 1 down).
- Shift-up, cnt=0, and op=00 -> no l/r activity; done one cycle after accept; q unchanged.
- Back-to-back: cmd_valid held high with a second command during SHIFT -> second accepted only in IDLE after the done cycle; cmd fields changed mid-command do not alter the active command.
- rst asserted on the 2nd cycle of a cnt=5 shift of 0xFF, fill=0 -> q=0x3F (2 shifts applied); no done; l=r=0; cmd_ready=1 next cycle.
